// File: rtl/wf_fetch_arbiter.sv
// Per-wavefront fetch arbiter. Request pulses collect in a pending bitmap, and one
// wavefront at a time is offered to fetch in round-robin order over a registered valid/ready port.
module wf_fetch_arbiter #(
    parameter int WF_PER_CU    = 40,
    parameter int WF_ID_LENGTH = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [WF_PER_CU-1:0]    wave_valid_entries,
    input  logic                    wf_init_en,
    input  logic [WF_ID_LENGTH-1:0] wf_init_wfid,
    input  logic                    wf_halt_en,
    input  logic [WF_ID_LENGTH-1:0] wf_halt_wfid,
    input  logic                    fetch_ready,
    output logic                    fetch_req_valid,
    output logic [WF_ID_LENGTH-1:0] fetch_req_wfid,
    output logic [WF_PER_CU-1:0]    pending_bitmap
);

    logic [WF_PER_CU-1:0]    pend_q, pend_d;
    logic                    fetch_req_valid_q, fetch_req_valid_d;
    logic [WF_ID_LENGTH-1:0] fetch_req_wfid_q, fetch_req_wfid_d;
    logic [WF_ID_LENGTH-1:0] last_q, last_d;

    logic [WF_PER_CU-1:0]    set_vec, halt_vec, elig, grant_oh;
    logic                    hi_found, grant_found, xfer, free, halt_hits_out;
    logic [WF_ID_LENGTH-1:0] grant_id;

    // Ids at or beyond WF_PER_CU never match a slot, so they decode to nothing.
    always_comb begin
        set_vec  = wave_valid_entries;
        halt_vec = '0;
        for (int i = 0; i < WF_PER_CU; i++) begin
            if (wf_init_en && wf_init_wfid == WF_ID_LENGTH'(i)) set_vec[i] = 1'b1;
            if (wf_halt_en && wf_halt_wfid == WF_ID_LENGTH'(i)) halt_vec[i] = 1'b1;
        end
    end

    // Round-robin: lowest eligible id above last, else wrap to the lowest id at or below last.
    always_comb begin
        elig        = pend_q & ~halt_vec;
        hi_found    = 1'b0;
        grant_found = 1'b0;
        grant_id    = '0;
        for (int i = 0; i < WF_PER_CU; i++) begin
            if (!hi_found && elig[i] && WF_ID_LENGTH'(i) > last_q) begin
                hi_found = 1'b1;
                grant_id = WF_ID_LENGTH'(i);
            end
        end
        grant_found = hi_found;
        for (int i = 0; i < WF_PER_CU; i++) begin
            if (!grant_found && elig[i] && WF_ID_LENGTH'(i) <= last_q) begin
                grant_found = 1'b1;
                grant_id    = WF_ID_LENGTH'(i);
            end
        end
    end

    always_comb begin
        xfer              = fetch_req_valid_q & fetch_ready;
        free              = !fetch_req_valid_q | xfer;
        halt_hits_out     = wf_halt_en && (wf_halt_wfid == fetch_req_wfid_q);
        fetch_req_valid_d = fetch_req_valid_q;
        fetch_req_wfid_d  = fetch_req_wfid_q;
        last_d            = last_q;
        grant_oh          = '0;
        if (free) begin
            if (grant_found) begin
                fetch_req_valid_d  = 1'b1;
                fetch_req_wfid_d   = grant_id;
                last_d             = grant_id;
                grant_oh[grant_id] = 1'b1;
            end else begin
                fetch_req_valid_d = 1'b0;
            end
        end else if (halt_hits_out) begin
            // Stalled offer for a finished wavefront is withdrawn; a transfer would have won.
            fetch_req_valid_d = 1'b0;
        end
        // New requests outlive the grant clear; halts outrank everything.
        pend_d = ((pend_q & ~grant_oh) | set_vec) & ~halt_vec;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q            <= '0;
            fetch_req_valid_q <= 1'b0;
            fetch_req_wfid_q  <= '0;
            last_q            <= WF_ID_LENGTH'(WF_PER_CU - 1);
        end else begin
            pend_q            <= pend_d;
            fetch_req_valid_q <= fetch_req_valid_d;
            fetch_req_wfid_q  <= fetch_req_wfid_d;
            last_q            <= last_d;
        end
    end

    assign fetch_req_valid = fetch_req_valid_q;
    assign fetch_req_wfid  = fetch_req_wfid_q;
    assign pending_bitmap  = pend_q;

endmodule

// File: tb/tb_wf_fetch_arbiter.sv
// Directed bench for wf_fetch_arbiter: expected grants go into a queue that a
// negedge monitor drains on every transfer; state checks are made inline.
module tb_wf_fetch_arbiter;
    localparam int N = 40;
    localparam int W = 6;

    logic         clk, rst;
    logic [N-1:0] wave_valid_entries;
    logic         wf_init_en, wf_halt_en, fetch_ready;
    logic [W-1:0] wf_init_wfid, wf_halt_wfid;
    logic         fetch_req_valid;
    logic [W-1:0] fetch_req_wfid;
    logic [N-1:0] pending_bitmap;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_q[$];

    wf_fetch_arbiter #(.WF_PER_CU(N), .WF_ID_LENGTH(W)) dut (
        .clk(clk), .rst(rst),
        .wave_valid_entries(wave_valid_entries),
        .wf_init_en(wf_init_en), .wf_init_wfid(wf_init_wfid),
        .wf_halt_en(wf_halt_en), .wf_halt_wfid(wf_halt_wfid),
        .fetch_ready(fetch_ready),
        .fetch_req_valid(fetch_req_valid), .fetch_req_wfid(fetch_req_wfid),
        .pending_bitmap(pending_bitmap)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [N-1:0] b(input int i);
        logic [N-1:0] one;
        one = 1;
        return one << i;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every handshake must match the next expected wfid.
    always @(negedge clk) begin
        if (!rst && fetch_req_valid && fetch_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL xfer_unexpected: got wfid %0d expected none at %0t", fetch_req_wfid, $time);
            end else begin
                int e;
                e = exp_q.pop_front();
                if (fetch_req_wfid !== W'(e)) begin
                    n_fail++;
                    $display("FAIL xfer_wfid: got %0d expected %0d at %0t", fetch_req_wfid, e, $time);
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        wave_valid_entries = '0;
        wf_init_en = 1'b0; wf_init_wfid = '0;
        wf_halt_en = 1'b0; wf_halt_wfid = '0;
        fetch_ready = 1'b1;
        tick(); tick();
        check("rst_valid", 64'(fetch_req_valid), 64'd0);
        check("rst_wfid", 64'(fetch_req_wfid), 64'd0);
        check("rst_pend", 64'(pending_bitmap), 64'd0);
        rst = 1'b0;
        tick(); tick();
        check("idle_valid", 64'(fetch_req_valid), 64'd0);

        // Single request: pulse in cycle 0, offered in cycle 2, gone in cycle 3.
        wave_valid_entries = b(5);
        exp_q.push_back(5);
        tick(); wave_valid_entries = '0;
        check("single_pend_c1", 64'(pending_bitmap), 64'(b(5)));
        check("single_valid_c1", 64'(fetch_req_valid), 64'd0);
        tick();
        check("single_valid_c2", 64'(fetch_req_valid), 64'd1);
        check("single_wfid_c2", 64'(fetch_req_wfid), 64'd5);
        check("single_pend_c2", 64'(pending_bitmap), 64'd0);
        tick();
        check("single_valid_c3", 64'(fetch_req_valid), 64'd0);

        // Set last to 17, then {2,17,39} must come out as 39, 2, 17.
        wave_valid_entries = b(17);
        exp_q.push_back(17);
        tick(); wave_valid_entries = '0;
        tick(); tick();
        wave_valid_entries = b(2) | b(17) | b(39);
        exp_q.push_back(39); exp_q.push_back(2); exp_q.push_back(17);
        tick(); wave_valid_entries = '0;
        tick(); check("rr_c2", 64'(fetch_req_wfid), 64'd39);
        tick(); check("rr_c3", 64'(fetch_req_wfid), 64'd2);
        tick(); check("rr_c4", 64'(fetch_req_wfid), 64'd17);
        tick(); check("rr_done_valid", 64'(fetch_req_valid), 64'd0);

        // Backpressure: 3 held for 4 cycles while 4 waits in pending.
        fetch_ready = 1'b0;
        wave_valid_entries = b(3) | b(4);
        exp_q.push_back(3); exp_q.push_back(4);
        tick(); wave_valid_entries = '0;
        tick();
        for (int c = 0; c < 4; c++) begin
            check("bp_valid", 64'(fetch_req_valid), 64'd1);
            check("bp_wfid", 64'(fetch_req_wfid), 64'd3);
            check("bp_pend", 64'(pending_bitmap), 64'(b(4)));
            if (c < 3) tick();
        end
        fetch_ready = 1'b1;
        tick(); check("bp_second", 64'(fetch_req_wfid), 64'd4);
        tick(); check("bp_done_valid", 64'(fetch_req_valid), 64'd0);

        // Halt of the stalled offer withdraws it next cycle.
        fetch_ready = 1'b0;
        wave_valid_entries = b(4);
        tick(); wave_valid_entries = '0;
        tick();
        check("halt_offered_pre", 64'(fetch_req_valid), 64'd1);
        wf_halt_en = 1'b1; wf_halt_wfid = 6'd4;
        tick(); wf_halt_en = 1'b0;
        check("halt_offered_valid", 64'(fetch_req_valid), 64'd0);
        check("halt_offered_pend", 64'(pending_bitmap), 64'd0);
        tick();
        check("halt_offered_stay", 64'(fetch_req_valid), 64'd0);

        // Halt beats a simultaneous set of the same wavefront.
        wave_valid_entries = b(7);
        wf_halt_en = 1'b1; wf_halt_wfid = 6'd7;
        tick(); wave_valid_entries = '0; wf_halt_en = 1'b0;
        check("halt_set_pend", 64'(pending_bitmap), 64'd0);
        tick();
        check("halt_set_valid", 64'(fetch_req_valid), 64'd0);

        // Init of 10 during its own grant cycle re-pends it: two transfers of 10.
        fetch_ready = 1'b1;
        wave_valid_entries = b(10);
        exp_q.push_back(10); exp_q.push_back(10);
        tick(); wave_valid_entries = '0;
        wf_init_en = 1'b1; wf_init_wfid = 6'd10;
        tick(); wf_init_en = 1'b0;
        check("init_first_wfid", 64'(fetch_req_wfid), 64'd10);
        check("init_repend", 64'(pending_bitmap), 64'(b(10)));
        tick();
        check("init_second_valid", 64'(fetch_req_valid), 64'd1);
        check("init_second_pend", 64'(pending_bitmap), 64'd0);
        tick();
        check("init_done_valid", 64'(fetch_req_valid), 64'd0);

        // Out-of-range init id is ignored.
        wf_init_en = 1'b1; wf_init_wfid = 6'd45;
        tick(); wf_init_en = 1'b0;
        check("oor_pend", 64'(pending_bitmap), 64'd0);
        tick();
        check("oor_valid", 64'(fetch_req_valid), 64'd0);

        // Asynchronous reset mid-cycle with an offer and a pending request outstanding.
        fetch_ready = 1'b0;
        wave_valid_entries = b(1) | b(2);
        tick(); wave_valid_entries = '0;
        tick();
        check("arst_pre_valid", 64'(fetch_req_valid), 64'd1);
        #3 rst = 1'b1;
        #1;
        check("arst_valid", 64'(fetch_req_valid), 64'd0);
        check("arst_wfid", 64'(fetch_req_wfid), 64'd0);
        check("arst_pend", 64'(pending_bitmap), 64'd0);
        tick();
        rst = 1'b0;
        fetch_ready = 1'b1;
        tick(); tick(); tick();
        check("post_rst_valid", 64'(fetch_req_valid), 64'd0);
        check("post_rst_pend", 64'(pending_bitmap), 64'd0);
        check("sb_empty", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/wf_fetch_arbiter.md
# wf_fetch_arbiter

Per-wavefront fetch-request arbiter between the issue stage's flow-control logic and instruction fetch. It accumulates the one-cycle request pulses on `wave_valid_entries` (plus first-fetch requests from wavefront dispatch) into a pending bitmap. It picks one wavefront at a time by round-robin and presents its id to fetch over a registered valid/ready handshake.

## Interface
Parameters:
- `WF_PER_CU`, 40, number of wavefront slots per CU.
- `WF_ID_LENGTH`, 6, width of a wavefront id.

Ports:
- `clk`  in  1  clock; every register samples on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `wave_valid_entries`  in  WF_PER_CU  request pulses from issue flow control; bit i means wavefront i needs a new instruction.
- `wf_init_en`  in  1  a new wavefront was dispatched and needs its first fetch.
- `wf_init_wfid`  in  WF_ID_LENGTH  id of the dispatched wavefront.
- `wf_halt_en`  in  1  a wavefront finished; cancel its request.
- `wf_halt_wfid`  in  WF_ID_LENGTH  id of the finished wavefront.
- `fetch_ready`  in  1  fetch accepts a request this cycle.
- `fetch_req_valid`  out  1  request offered to fetch (registered).
- `fetch_req_wfid`  out  WF_ID_LENGTH  wavefront id of the offered request (registered).
- `pending_bitmap`  out  WF_PER_CU  current pending register, for trace/debug.

## Operation
- **State:**
  - pending register P[WF_PER_CU-1:0].
  - Output register: `fetch_req_valid`, `fetch_req_wfid`.
  - Round-robin pointer `last` (WF_ID_LENGTH bits).
- **Decodes:**
  - S = `wave_valid_entries` | onehot(`wf_init_wfid`) when `wf_init_en`.
  - H = onehot(`wf_halt_wfid`) when `wf_halt_en`.
  - An id ≥ WF_PER_CU decodes to all zeros and is ignored.
- **Transfer:** occurs when `fetch_req_valid` & `fetch_ready` are both high.
- **Load:**
  - The output register may load when free = !`fetch_req_valid` | transfer.
  - E = P & ~H. If free and E ≠ 0, load wfid G, chosen by round-robin over E.
  - On a load: `fetch_req_valid`←1, `fetch_req_wfid`←G, `last`←G.
  - If free and E = 0: `fetch_req_valid`←0 and `fetch_req_wfid` holds its value.
- **Round-robin:**
  - G is the first set bit of E searching from index `last`+1 upward.
  - The search wraps from WF_PER_CU-1 to 0; WF_PER_CU need not be a power of 2.
  - If `last` is the only set bit, it is granted.
- **Pending update:** P_next = (P & ~grant_onehot | S) & ~H.
  - Set beats grant-clear: a request arriving for G in its grant cycle stays pending.
  - Halt beats set.
- **Halt of offered request:**
  - If `wf_halt_en` names `fetch_req_wfid` while `fetch_req_valid`=1 and no transfer happens, `fetch_req_valid`←0 next cycle.
  - The output is then free the following cycle.
  - If a transfer happens in the same cycle, the transfer stands.
- **Hold:** `fetch_req_valid`/`fetch_req_wfid` remain stable while valid and not ready.
- `pending_bitmap` = P.

## Timing
- **Reset values:**
  - P=0, `fetch_req_valid`=0, `fetch_req_wfid`=0, `last`=WF_PER_CU-1 (so the first search starts at 0).
  - `pending_bitmap`=0.
  - Asserting `rst` mid-request drops any offered and pending request immediately.
- **Latency:**
  - A request pulse in cycle N sets P at the end of N.
  - With the output free, the wavefront is loaded at the end of N+1, so `fetch_req_valid`=1 in N+2.
  - There is no combinational bypass from S to the output.
- **Throughput:** with `fetch_ready` held high, one grant per cycle with back-to-back valid.
- **Combinational paths:** none from inputs to outputs; all outputs are registers.
- **Fairness:** with k pending bits and `fetch_ready` high, every pending wavefront is granted within k cycles.

## Test plan
- **Reset:** assert `rst` asynchronously mid-cycle -> all outputs 0 immediately.
  - After deassert with no requests, `fetch_req_valid` stays 0.
- **Single request:** `wave_valid_entries`=bit 5 in cycle 0, `fetch_ready`=1 -> `fetch_req_valid`=1, `fetch_req_wfid`=5 in cycle 2, `fetch_req_valid`=0 in cycle 3.
  - P is 0 from cycle 2 onward.
- **Round-robin wrap:** bits {2,17,39} pending, `last`=17, `fetch_ready`=1 -> grants 39, 2, 17 on consecutive cycles.
- **Backpressure:** bits {3,4} pending, `fetch_ready`=0 for 4 cycles -> `fetch_req_wfid`=3 stable and P={4}.
  - Raising `fetch_ready` gives transfers of 3 then 4 on consecutive cycles.
- **Halt cases:**
  - `wf_halt_wfid`=4 while 4 is offered and not ready -> `fetch_req_valid`=0 next cycle.
  - Halt and `wave_valid_entries` bit 7 in the same cycle for wfid 7 -> bit 7 not pending.
- **Init and out-of-range ids:**
  - `wf_init_en` with wfid 10 and simultaneous grant of 10 -> 10 re-pended and offered again.
  - `wf_init_wfid`=45 -> ignored, P unchanged.
